// File: rtl/dbg_mem_bridge_pkg.sv
// Shared types for the debug memory bridge: error codes, FSM states, strobe decode.
package debug_pkg;

  typedef enum logic [1:0] {
    MERR_NONE    = 2'd0,
    MERR_ALIGN   = 2'd1,
    MERR_BUS     = 2'd2,
    MERR_TIMEOUT = 2'd3
  } mem_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

  // Returns {legal, offset}; offset is the lowest enabled byte lane.
  function automatic logic [2:0] strobe_offset(input logic [3:0] st);
    logic [2:0] res;
    res = 3'b000;
    case (st)
      4'b0001: res = 3'b100;
      4'b0010: res = 3'b101;
      4'b0100: res = 3'b110;
      4'b1000: res = 3'b111;
      4'b0011: res = 3'b100;
      4'b1100: res = 3'b110;
      4'b1111: res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dbg_mem_bridge_lane_align.sv
// Combinational byte-lane steering: write data shifted into lane position,
// read data extracted from its lanes, masked to access size and zero-extended.
module dbg_mem_lane_align (
  input  logic [1:0]  wr_off_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] wr_data_o,
  input  logic [1:0]  rd_off_i,
  input  logic [3:0]  rd_be_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);

  logic [3:0]  lane_mask;
  logic [31:0] byte_mask;

  always_comb begin
    wr_data_o = wr_data_i << {wr_off_i, 3'b000};
    // Shifting the strobe down by the offset yields the right-aligned size mask.
    lane_mask = rd_be_i >> rd_off_i;
    byte_mask = '0;
    for (int i = 0; i < 4; i++) begin
      byte_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    rd_data_o = (rd_data_i >> {rd_off_i, 3'b000}) & byte_mask;
  end

endmodule

// File: rtl/dbg_mem_bridge.sv
// Converts one dm abstract memory command into a single req/gnt/rvalid bus transaction.
// Request launches the cycle after en is sampled; gnt/rvalid may stall up to TIMEOUT_CYCLES.
module dbg_mem_bridge
  import debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        am_en_i,
  input  logic        am_wr_i,
  input  logic [3:0]  am_st_i,
  input  logic [31:0] am_ad_i,
  input  logic [31:0] am_di_i,
  output logic [31:0] am_do_o,
  output logic        am_done_o,
  output logic [1:0]  am_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e   state_q, state_d;
  mem_err_e        err_q, err_d;
  logic [1:0]      off_q, off_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     do_q, do_d;
  logic            done_q, done_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [2:0]  st_dec;
  logic        cmd_legal;
  logic        capture;
  logic        timed_out;
  logic [31:0] wdata_shifted;
  logic [31:0] rdata_aligned;

  dbg_mem_lane_align u_align (
    .wr_off_i  (am_ad_i[1:0]),
    .wr_data_i (am_di_i),
    .wr_data_o (wdata_shifted),
    .rd_off_i  (off_q),
    .rd_be_i   (be_q),
    .rd_data_i (mem_rdata_i),
    .rd_data_o (rdata_aligned)
  );

  assign st_dec    = strobe_offset(am_st_i);
  assign cmd_legal = st_dec[2] && (st_dec[1:0] == am_ad_i[1:0]);
  assign timed_out = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    do_d    = do_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (am_en_i) begin
          err_d = MERR_NONE;
          if (cmd_legal) begin
            state_d = ST_REQ;
            done_d  = 1'b0;
            req_d   = 1'b1;
            we_d    = am_wr_i;
            be_d    = am_st_i;
            off_d   = am_ad_i[1:0];
            addr_d  = {am_ad_i[31:2], 2'b00};
            wdata_d = wdata_shifted;
            cnt_d   = '0;
          end else begin
            state_d = ST_DONE;
            err_d   = MERR_ALIGN;
            done_d  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + TO_W'(1);
        if (mem_gnt_i) begin
          req_d = 1'b0;
          if (mem_rvalid_i) begin
            capture = 1'b1;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end else if (timed_out) begin
          req_d   = 1'b0;
          err_d   = MERR_TIMEOUT;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + TO_W'(1);
        if (mem_rvalid_i) begin
          capture = 1'b1;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (timed_out) begin
          err_d   = MERR_TIMEOUT;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        // Held enable must not retrigger; dm has to drop it first.
        if (!am_en_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (mem_err_i) begin
        err_d = MERR_BUS;
      end else if (!we_q) begin
        do_d = rdata_aligned;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= MERR_NONE;
      off_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      do_q    <= '0;
      done_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      do_q    <= do_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign am_do_o     = do_q;
  assign am_done_o   = done_q;
  assign am_err_o    = err_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Directed bench for dbg_mem_bridge with a result scoreboard and TIMEOUT_CYCLES=8.
module tb_dbg_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        am_en_i, am_wr_i;
  logic [3:0]  am_st_i;
  logic [31:0] am_ad_i, am_di_i;
  logic [31:0] am_do_o;
  logic        am_done_o;
  logic [1:0]  am_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  dbg_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .am_en_i      (am_en_i),
    .am_wr_i      (am_wr_i),
    .am_st_i      (am_st_i),
    .am_ad_i      (am_ad_i),
    .am_di_i      (am_di_i),
    .am_do_o      (am_do_o),
    .am_done_o    (am_done_o),
    .am_err_o     (am_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle first so the bridge is back in IDLE, then present the command.
  task automatic issue(input logic wr, input logic [3:0] st, input logic [31:0] ad,
                       input logic [31:0] di, input bit hold);
    step();
    am_en_i = 1'b1;
    am_wr_i = wr;
    am_st_i = st;
    am_ad_i = ad;
    am_di_i = di;
    step();
    if (!hold) am_en_i = 1'b0;
  endtask

  task automatic respond(input bit gnt, input bit rv, input bit err, input logic [31:0] rd);
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_err_i    = err;
    mem_rdata_i  = rd;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = 32'h0;
  endtask

  task automatic finish_txn(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (am_done_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_done"}, {31'b0, am_done_o}, 32'd1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_do"}, am_do_o, e.d);
      chk({tag, "_err"}, {30'b0, am_err_o}, {30'b0, e.e});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    am_en_i = 0; am_wr_i = 0; am_st_i = 0; am_ad_i = 0; am_di_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
    #1;
    chk("rst_done",  {31'b0, am_done_o}, 32'd1);
    chk("rst_do",    am_do_o, 32'h0);
    chk("rst_err",   {30'b0, am_err_o}, 32'd0);
    chk("rst_req",   {31'b0, mem_req_o}, 32'd0);
    chk("rst_be",    {28'b0, mem_be_o}, 32'd0);
    chk("rst_addr",  mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    step(); step();
    #2 rst = 1'b0;

    // Word read, response two cycles after request.
    issue(1'b0, 4'b1111, 32'h1000_0004, 32'h0, 1'b0);
    sb.push_back('{d: 32'hDEAD_BEEF, e: 2'd0});
    chk("wrd_req",  {31'b0, mem_req_o}, 32'd1);
    chk("wrd_addr", mem_addr_o, 32'h1000_0004);
    chk("wrd_be",   {28'b0, mem_be_o}, 32'hF);
    chk("wrd_we",   {31'b0, mem_we_o}, 32'd0);
    chk("wrd_busy", {31'b0, am_done_o}, 32'd0);
    step(); step();
    chk("wrd_hold_req", {31'b0, mem_req_o}, 32'd1);
    chk("wrd_hold_busy", {31'b0, am_done_o}, 32'd0);
    respond(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("wrd_req_drop", {31'b0, mem_req_o}, 32'd0);
    finish_txn("wrd");

    // Byte write at lane 3, grant and response in separate cycles.
    issue(1'b1, 4'b1000, 32'h2000_0003, 32'h0000_00A5, 1'b0);
    sb.push_back('{d: 32'hDEAD_BEEF, e: 2'd0});
    chk("bw_be",    {28'b0, mem_be_o}, 32'h8);
    chk("bw_wdata", mem_wdata_o, 32'hA500_0000);
    chk("bw_we",    {31'b0, mem_we_o}, 32'd1);
    chk("bw_addr",  mem_addr_o, 32'h2000_0000);
    respond(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bw_resp_req",  {31'b0, mem_req_o}, 32'd0);
    chk("bw_resp_busy", {31'b0, am_done_o}, 32'd0);
    respond(1'b0, 1'b1, 1'b0, 32'h5555_5555);
    finish_txn("bw");

    // Upper half read.
    issue(1'b0, 4'b1100, 32'h0000_2002, 32'h0, 1'b0);
    sb.push_back('{d: 32'h0000_1234, e: 2'd0});
    chk("hr_addr", mem_addr_o, 32'h0000_2000);
    respond(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    finish_txn("hr");

    // Low-half strobe at a high-half address is rejected without bus activity.
    issue(1'b0, 4'b0011, 32'h0000_2002, 32'h0, 1'b0);
    sb.push_back('{d: 32'h0000_1234, e: 2'd1});
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req_o) cnt++;
      if (i < 2) step();
    end
    chk("mis_no_req", cnt, 32'd0);
    finish_txn("mis");

    // Grant withheld: request lasts TIMEOUT_CYCLES, enable held into DONE.
    issue(1'b0, 4'b1111, 32'h0000_3000, 32'h0, 1'b1);
    sb.push_back('{d: 32'h0000_1234, e: 2'd3});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o) cnt++;
      step();
    end
    chk("to_req_cycles", cnt, 32'd8);
    finish_txn("to");
    respond(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("late_err", {30'b0, am_err_o}, 32'd3);
    chk("late_do",  am_do_o, 32'h0000_1234);
    chk("late_req", {31'b0, mem_req_o}, 32'd0);
    am_en_i = 1'b0;
    step();
    issue(1'b0, 4'b1111, 32'h0000_4000, 32'h0, 1'b0);
    sb.push_back('{d: 32'h0BAD_F00D, e: 2'd0});
    chk("post_to_req", {31'b0, mem_req_o}, 32'd1);
    respond(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
    finish_txn("post_to");

    // Bus error keeps previous read data; held enable must not retrigger.
    issue(1'b0, 4'b1111, 32'h0000_5000, 32'h0, 1'b1);
    sb.push_back('{d: 32'h0BAD_F00D, e: 2'd2});
    respond(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    finish_txn("berr");
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req_o) cnt++;
      step();
    end
    chk("held_en_no_req", cnt, 32'd0);
    am_en_i = 1'b0;
    step();
    issue(1'b0, 4'b0010, 32'h0000_5001, 32'h0, 1'b0);
    sb.push_back('{d: 32'h0000_00AB, e: 2'd0});
    chk("rearm_req", {31'b0, mem_req_o}, 32'd1);
    chk("rearm_be",  {28'b0, mem_be_o}, 32'h2);
    respond(1'b1, 1'b1, 1'b0, 32'h0000_AB00);
    finish_txn("rearm");

    // Asynchronous reset while waiting for the response.
    issue(1'b0, 4'b1111, 32'h0000_6000, 32'h0, 1'b0);
    respond(1'b1, 1'b0, 1'b0, 32'h0);
    chk("resp_busy", {31'b0, am_done_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_done", {31'b0, am_done_o}, 32'd1);
    chk("arst_do",   am_do_o, 32'h0);
    chk("arst_err",  {30'b0, am_err_o}, 32'd0);
    chk("arst_req",  {31'b0, mem_req_o}, 32'd0);
    chk("arst_addr", mem_addr_o, 32'h0);
    chk("arst_be",   {28'b0, mem_be_o}, 32'd0);
    step();
    #2 rst = 1'b0;
    issue(1'b1, 4'b1111, 32'h0000_6000, 32'h1122_3344, 1'b0);
    sb.push_back('{d: 32'h0000_0000, e: 2'd0});
    chk("post_rst_wdata", mem_wdata_o, 32'h1122_3344);
    chk("post_rst_we",    {31'b0, mem_we_o}, 32'd1);
    respond(1'b1, 1'b1, 1'b0, 32'h0);
    finish_txn("post_rst");

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_mem_bridge.md
Name: dbg_mem_bridge

Overview:
Downstream stage of the debug module's abstract memory-access port. Converts one dm memory command (en/wr/strobe/address/data) into a single transaction on the core-clock data-memory request/grant/response bus. Returns right-aligned read data, a level "done" status (low while busy) and an error code. Runs entirely in the clk domain.

Parameters:
TIMEOUT_CYCLES, 256, cycles from request launch to abort if grant or response never arrives (minimum 2)
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
am_en_i  in  1  command request from dm (onebit_sig_e), level
am_wr_i  in  1  1=write, 0=read (onebit_sig_e)
am_st_i  in  4  byte strobe pattern
am_ad_i  in  32  byte address
am_di_i  in  32  write data, right-aligned
am_do_o  out  32  read data, right-aligned, zero-extended
am_done_o  out  1  high when idle/complete, low while transaction in flight (onebit_sig_e)
am_err_o  out  2  status: 0 ok, 1 misaligned/illegal strobe, 2 bus error, 3 timeout
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write enable
mem_be_o  out  4  bus byte enables
mem_addr_o  out  32  word-aligned address {am_ad_i[31:2],2'b00}
mem_wdata_o  out  32  write data shifted into lane position
mem_gnt_i  in  1  bus grant
mem_rvalid_i  in  1  bus response valid (reads and writes)
mem_rdata_i  in  32  bus read data, word lanes
mem_err_i  in  1  bus error, qualified by mem_rvalid_i

Behaviour:
- Reset (async): state IDLE; am_done_o=1, am_do_o=0, am_err_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, counter=0.
- FSM states IDLE, REQ, RESP, DONE.
- IDLE: am_en_i=1 -> latch wr/strobe/address/data, clear am_err_o, am_done_o<=0 next cycle. Legal strobes: 0001,0010,0100,1000 (byte), 0011,1100 (half), 1111 (word); offset = index of lowest set bit, must equal am_ad_i[1:0]. Legal -> REQ with mem_req_o=1, be=strobe, wdata=am_di_i<<(8*offset). Illegal -> DONE, am_err_o=1, no bus activity.
- REQ: mem_req_o and all mem_* outputs held stable until mem_gnt_i. gnt without rvalid -> RESP, mem_req_o<=0. gnt and rvalid same cycle -> DONE directly.
- RESP: wait mem_rvalid_i -> DONE.
- Response capture: read -> am_do_o = (mem_rdata_i>>(8*offset)) masked to access size, zero-extended; write -> am_do_o unchanged. mem_err_i=1 -> am_err_o=2, am_do_o unchanged.
- Timeout: counter cleared on IDLE->REQ, increments each cycle in REQ/RESP; reaching TIMEOUT_CYCLES -> DONE, mem_req_o<=0, am_err_o=3. Grant/response in the same cycle as timeout wins (no error).
- DONE: am_done_o=1; stay while am_en_i=1 (no retrigger on held enable); am_en_i=0 -> IDLE. am_do_o/am_err_o hold until next accepted command.
- mem_rvalid_i/mem_gnt_i seen in IDLE or DONE ignored (late response after timeout is dropped).
- Latency, legal read, immediate gnt+rvalid: en sampled cycle 0, req cycle 1, done high cycle 2.
- am_* inputs ignored outside IDLE.

Decomposition:
- debug_pkg: enum mem_err_e {MERR_NONE, MERR_ALIGN, MERR_BUS, MERR_TIMEOUT}; FSM state enum; function strobe_offset(st) returning {legal, offset[1:0]}.
- Optional sub-module dbg_mem_lane_align: combinational write shift / read extract by offset and size; everything else in one module.

Test Plan:
- Word read, addr 0x1000_0004, st 1111, gnt+rvalid after 2 cycles, rdata 0xDEADBEEF -> mem_addr 0x1000_0004, be 1111, am_do 0xDEADBEEF, err 0, done low until response, high after.
- Byte write, addr 0x2000_0003, st 1000, di 0x0000_00A5 -> mem_be 1000, mem_wdata 0xA500_0000, we 1, err 0.
- Half read, addr 0x2002, st 1100, rdata 0x1234_5678 -> am_do 0x0000_1234; st 0011 at addr 0x2002 -> err 1, mem_req never asserted.
- Grant withheld, TIMEOUT_CYCLES=8 -> mem_req drops after 8 cycles, err 3, done high; late rvalid in DONE ignored, next command proceeds normally.
- rvalid with mem_err_i=1 -> err 2, am_do keeps previous value; am_en held high in DONE -> no second mem_req until en drops and rises.
- rst asserted in RESP -> all outputs to reset values immediately, done 1, next command starts cleanly.
